// File: rtl/rom_burst_arbiter.sv
// rtl/rom_burst_arbiter.sv - round-robin burst arbiter sharing one synchronous-read ROM between two requesters
module rom_burst_arbiter #(
    parameter int AW = 6,
    parameter int DW = 4,
    parameter int LW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    input  logic [LW-1:0] len0,
    output logic          ack0,
    input  logic          req1,
    input  logic [AW-1:0] addr1,
    input  logic [LW-1:0] len1,
    output logic          ack1,
    output logic          rom_en,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_dout,
    output logic          rd_valid,
    output logic          rd_id,
    output logic [DW-1:0] rd_data,
    output logic          rd_last,
    output logic          busy
);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t        state_q, state_d;
    logic          id_q, id_d;
    logic          last_gnt_q, last_gnt_d;
    logic [LW-1:0] count_q, count_d;
    logic          rom_en_q, rom_en_d;
    logic [AW-1:0] rom_addr_q, rom_addr_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic          rd_valid_q, rd_valid_d;
    logic          rd_id_q, rd_id_d;
    logic          rd_last_q, rd_last_d;
    logic          busy_q, busy_d;
    logic          grant_vld;
    logic          grant_id;

    // Contention goes to whoever was not served last; a lone request wins outright.
    assign grant_vld = req0 | req1;
    assign grant_id  = (req0 && req1) ? ~last_gnt_q : req1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            id_q       <= 1'b0;
            last_gnt_q <= 1'b1;
            count_q    <= '0;
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_id_q    <= 1'b0;
            rd_last_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            last_gnt_q <= last_gnt_d;
            count_q    <= count_d;
            rom_en_q   <= rom_en_d;
            rom_addr_q <= rom_addr_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            rd_valid_q <= rd_valid_d;
            rd_id_q    <= rd_id_d;
            rd_last_q  <= rd_last_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (grant_vld) state_d = S_BURST;
            S_BURST: if (count_q == '0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        id_d       = id_q;
        last_gnt_d = last_gnt_q;
        count_d    = count_q;
        rom_en_d   = 1'b0;
        rom_addr_d = rom_addr_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    id_d       = grant_id;
                    last_gnt_d = grant_id;
                    rom_addr_d = grant_id ? addr1 : addr0;
                    count_d    = grant_id ? len1 : len0;
                    rom_en_d   = 1'b1;
                    ack0_d     = ~grant_id;
                    ack1_d     = grant_id;
                end
            end
            S_BURST: begin
                if (count_q != '0) begin
                    rom_addr_d = rom_addr_q + 1'b1;
                    count_d    = count_q - 1'b1;
                    rom_en_d   = 1'b1;
                end
            end
            default: ;
        endcase
        // Return side mirrors the issue side one cycle later, matching ROM latency.
        rd_valid_d = rom_en_q;
        rd_id_d    = id_q;
        rd_last_d  = rom_en_q && (count_q == '0);
        busy_d     = (state_d == S_BURST) || rd_valid_d;
    end

    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign rom_en   = rom_en_q;
    assign rom_addr = rom_addr_q;
    assign rd_valid = rd_valid_q;
    assign rd_id    = rd_id_q;
    assign rd_last  = rd_last_q;
    assign rd_data  = rd_valid_q ? rom_dout : '0;
    assign busy     = busy_q;

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// tb/tb_rom_burst_arbiter.sv - scoreboard bench for rom_burst_arbiter with a transaction-level reference model
module tb_rom_burst_arbiter;

    logic       clk;
    logic       rst;
    logic       req0, req1;
    logic [5:0] addr0, addr1;
    logic [3:0] len0, len1;
    logic       ack0, ack1;
    logic       rom_en;
    logic [5:0] rom_addr;
    logic [3:0] rom_dout;
    logic       rd_valid, rd_id, rd_last, busy;
    logic [3:0] rd_data;

    logic [3:0] mem [64];
    logic [5:0] exp_q [$];
    bit         last_g;
    int         n_checks;
    int         n_pass;

    rom_burst_arbiter #(.AW(6), .DW(4), .LW(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .len0(len0), .ack0(ack0),
        .req1(req1), .addr1(addr1), .len1(len1), .ack1(ack1),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_dout(rom_dout),
        .rd_valid(rd_valid), .rd_id(rd_id), .rd_data(rd_data),
        .rd_last(rd_last), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 4'(i);
        rom_dout = '0;
    end

    always @(posedge clk) if (rom_en) rom_dout <= mem[rom_addr];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic bit pick(input bit p0, input bit p1);
        if (p0 && p1) return ~last_g;
        return p1;
    endfunction

    // Scoreboard consumer: every presented beat must match the head of the expected queue.
    bit prev_last, prev_ack;
    always @(negedge clk) begin
        if (rst) begin
            prev_last = 1'b0;
            prev_ack  = 1'b0;
        end else begin
            if (prev_last) chk("gap_after_last", int'(rd_valid), 0);
            if (prev_ack)  chk("ack_one_cycle", int'(ack0 | ack1), 0);
            if (rd_valid) begin
                if (exp_q.size() == 0) chk("unexpected_beat", int'(rd_valid), 0);
                else chk("rd_beat", int'({rd_id, rd_data, rd_last}), int'(exp_q.pop_front()));
            end else begin
                chk("idle_rd_zero", int'({rd_data, rd_last}), 0);
            end
            prev_last = rd_valid && rd_last;
            prev_ack  = ack0 | ack1;
        end
    end

    task automatic expect_grant(input bit id, input int a, input int l);
        bit seen = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                seen = 1;
                break;
            end
        end
        chk("grant_seen", int'(seen), 1);
        chk("grant_id", int'({ack1, ack0}), id ? 2 : 1);
        chk("grant_addr", int'(rom_addr), a % 64);
        for (int k = 0; k <= l; k++)
            exp_q.push_back({id, 4'(((a + k) % 64) % 16), k == l});
        last_g = id;
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !rd_valid) break;
        end
        chk("drained", exp_q.size(), 0);
        chk("busy_idle", int'(busy), 0);
        chk("rom_en_idle", int'(rom_en), 0);
    endtask

    task automatic round(input bit r0, input int a0, input int l0,
                         input bit r1, input int a1, input int l1);
        bit p0, p1, id;
        @(negedge clk);
        req0 = r0; addr0 = 6'(a0); len0 = 4'(l0);
        req1 = r1; addr1 = 6'(a1); len1 = 4'(l1);
        p0 = r0;
        p1 = r1;
        while (p0 || p1) begin
            id = pick(p0, p1);
            expect_grant(id, id ? a1 : a0, id ? l1 : l0);
            if (id) begin
                req1 = 0; p1 = 0;
                addr1 = 6'($urandom_range(63, 0)); len1 = 4'($urandom_range(15, 0));
            end else begin
                req0 = 0; p0 = 0;
                addr0 = 6'($urandom_range(63, 0)); len0 = 4'($urandom_range(15, 0));
            end
        end
        wait_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit found;
        bit id;
        int a0, a1, l0, l1;
        n_checks = 0;
        n_pass   = 0;
        last_g   = 1;
        rst = 1; req0 = 0; req1 = 0; addr0 = 0; addr1 = 0; len0 = 0; len1 = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rom_en", int'(rom_en), 0);
        chk("rst_rom_addr", int'(rom_addr), 0);
        chk("rst_ack", int'({ack1, ack0}), 0);
        chk("rst_rd", int'({rd_valid, rd_id, rd_last, rd_data}), 0);
        chk("rst_busy", int'(busy), 0);
        @(negedge clk) rst = 0;

        round(1, 5, 3, 0, 0, 0);
        round(0, 0, 0, 1, 62, 2);
        round(1, 10, 0, 1, 33, 0);
        round(1, 11, 0, 1, 34, 0);
        round(1, 20, 0, 0, 0, 0);

        // Abort a long burst with an asynchronous reset in the middle of its 6th beat.
        @(negedge clk);
        req0 = 1; addr0 = 0; len0 = 15;
        expect_grant(0, 0, 15);
        found = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (rom_en && rom_addr == 6'd5) begin
                found = 1;
                break;
            end
        end
        chk("sixth_beat_seen", int'(found), 1);
        #1 rst = 1;
        #1;
        chk("async_rom_en", int'(rom_en), 0);
        chk("async_rd_valid", int'(rd_valid), 0);
        chk("async_ack0", int'(ack0), 0);
        chk("async_busy", int'(busy), 0);
        exp_q.delete();
        last_g = 1;
        len0 = 1;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 0;
        expect_grant(0, 0, 1);
        req0 = 0;
        wait_idle();

        // Requester 0 held high continuously; requester 1 joins and must not starve.
        @(negedge clk);
        a0 = $urandom_range(63, 0);
        a1 = $urandom_range(63, 0);
        l1 = $urandom_range(3, 0);
        req0 = 1; addr0 = 6'(a0); len0 = 1;
        expect_grant(0, a0, 1);
        req1 = 1; addr1 = 6'(a1); len1 = 4'(l1);
        for (int k = 0; k < 6; k++) begin
            id = pick(1, 1);
            expect_grant(id, id ? a1 : a0, id ? l1 : 1);
            if (k == 5) begin
                req0 = 0;
                req1 = 0;
            end
        end
        wait_idle();

        for (int r = 0; r < 40; r++) begin
            int sel;
            sel = $urandom_range(2, 0);
            a0 = $urandom_range(63, 0); l0 = $urandom_range(15, 0);
            a1 = $urandom_range(63, 0); l1 = $urandom_range(15, 0);
            round(sel != 1, a0, l0, sel != 0, a1, l1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rom_burst_arbiter.md
Name: rom_burst_arbiter

Overview:
- Shares one 64x4 synchronous-read ROM (1-cycle read latency, en/addr in, dout out) between two requesters.
- Each requester asks for a burst of consecutive ROM words. The arbiter grants round-robin, sequences the ROM address and enable, and returns tagged read data with a last-beat flag.
- Sits between the ROM and its consumers.

Parameters:
- AW, 6, ROM address width (depth 2^AW).
- DW, 4, ROM data width.
- LW, 4, burst length field width; len encodes beats-1 (1..2^LW beats).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0  in  1  requester 0 burst request; held until ack0.
- addr0  in  AW  requester 0 start address.
- len0  in  LW  requester 0 beats-1.
- ack0  out  1  one-cycle pulse: requester 0 burst accepted.
- req1, addr1, len1, ack1  as above for requester 1.
- rom_en  out  1  ROM read enable (registered).
- rom_addr  out  AW  ROM address (registered).
- rom_dout  in  DW  ROM read data, valid the cycle after the rom_en cycle.
- rd_valid  out  1  read data valid.
- rd_id  out  1  requester owning the current rd_data.
- rd_data  out  DW  equals rom_dout when rd_valid, else 0.
- rd_last  out  1  final beat of a burst; only high when rd_valid is high.
- busy  out  1  high in BURST state or while rd_valid is high.

Behaviour:
- Reset (asynchronous, immediate, no clock needed):
  - state=IDLE; rom_en=0, rom_addr=0, ack0=ack1=0.
  - rd_valid=0, rd_id=0, rd_last=0, busy=0.
  - Round-robin pointer favours requester 0.
  - A burst in flight is abandoned; no further beats are issued after reset releases.
- FSM states: IDLE, BURST.
- IDLE:
  - At an edge with any req high, latch id, start address and count=len; go to BURST.
  - Next cycle: rom_en=1, rom_addr=start, ack<id>=1 for exactly that cycle.
- Arbitration:
  - Only one req high: grant it.
  - Both high: grant the requester not granted last; after reset, grant requester 0.
  - Pointer updates only on grant.
- BURST: at each edge:
  - count!=0: rom_addr<=rom_addr+1 modulo 2^AW (63 wraps to 0), count<=count-1.
  - count==0: state<=IDLE, rom_en<=0, rom_addr holds.
  - A burst therefore occupies len+1 consecutive rom_en cycles.
- Requests are not sampled in BURST. Re-arbitration happens on the first IDLE edge, so at least one rom_en=0 cycle separates bursts.
- A requester must deassert req in its ack cycle unless it wants another burst. A req still high after the burst's final rom_en cycle is treated as a new request.
- addr/len are sampled only at the grant edge; later changes have no effect.
- Read return pipeline:
  - rd_valid, rd_id and rd_last are rom_en, the burst id and (count==0) delayed by one register stage.
  - rd_data is combinational from rom_dout, gated by rd_valid.
  - Latency: the beat issued in cycle t appears on rd_data in cycle t+1.
- Ports not listed as combinational are registered.

Test Plan:
Bench ROM model: synchronous, mem[i]=i[3:0].
1. After reset, req0=1, addr0=5, len0=3:
   - ack0 high for one cycle.
   - rom_addr 5,6,7,8 with rom_en high for 4 cycles.
   - rd_data 5,6,7,8 one cycle later, rd_id=0, rd_last only with data 8, busy falls after the last beat.
2. req1, addr1=62, len1=2 (wrap): rom_addr 62,63,0 -> rd_data 14,15,0, rd_id=1, rd_last on 0.
3. req0 and req1 raised in the same cycle after reset, both len=0:
   - requester 0 is served first, then requester 1 after one rom_en=0 gap.
   - Raise both again: requester 0 is granted (last grant was 1).
4. req0, addr0=20, len0=0: a single beat; rd_valid=rd_last=1 in the same cycle, rd_data=4.
5. req0, addr0=0, len0=15; assert rst asynchronously during the 6th beat (mid-cycle):
   - rom_en, rd_valid, ack0 and busy drop to 0 immediately.
   - After release with req0 still high: a new burst from address 0 is issued.
6. req0 held high continuously with len0=1, then req1 raised:
   - req1 is granted at the next IDLE edge.
   - Grants then alternate 0/1 with no starvation.
